ins_encode: RTL and testbench
=============================

Name: ins_encode

Overview:
- Instruction encoder/issuer: the producing end of the 12-bit instruction word consumed by the instruction decode stage.
- Accepts decoded operation fields over a valid/ready handshake and emits instruction words over a second valid/ready handshake.
- Immediates too wide for the 5-bit field are split: a PREFIX word goes out first, then the main word.
- Sits between the micro-op sequencer and the instruction bus that feeds the decoder.

Parameters:
- IMM_W, 13, width of the input immediate; must satisfy 6 <= IMM_W <= 13.
- PFX_OP, 4'hF, opcode reserved for PREFIX words; illegal as an input opcode.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- in_op  in  4  opcode.
- in_rd  in  3  destination register.
- in_imm  in  IMM_W  signed immediate.
- out_valid  out  1  inst word valid.
- out_ready  in  1  downstream accepts the word.
- inst  out  12  instruction word.
- inst_is_pfx  out  1  current word is a PREFIX.
- err_illegal  out  1  one-cycle pulse when an illegal opcode is dropped.
- word_cnt  out  CNT_W  count of accepted output words; saturates at all-ones.

Behaviour:
- Reset (async, active-low): state IDLE; out_valid=0, inst=12'h000, inst_is_pfx=0, err_illegal=0, word_cnt=0, in_ready=0 while rst_n=0. Asserting reset mid-operation discards any pending PREFIX or main word.
- Main word format: inst[11:8]=op, inst[7:5]=rd, inst[4:0]=imm[4:0].
- PREFIX word format: inst[11:8]=PFX_OP, inst[7:0]=imm[IMM_W-1:5], zero-extended to 8 bits.
- Short form: imm[IMM_W-1:4] is all zeros or all ones, i.e. the immediate sign-extends from 5 bits.
- States: IDLE, EMIT_PFX, EMIT_MAIN.
- in_ready=1 only in IDLE while out_valid=0, or in IDLE while (out_valid && out_ready). This gives back-to-back issue of single words.
- Accept in IDLE (in_valid && in_ready):
  - in_op==PFX_OP: drop the fields, pulse err_illegal for 1 cycle, no output, stay in IDLE.
  - Short form: register the main word. Next cycle out_valid=1, inst_is_pfx=0. State stays IDLE. Latency is 1 cycle.
  - Long form: register the PREFIX word and hold op/rd/imm[4:0]. Next cycle out_valid=1, inst_is_pfx=1. Go to EMIT_PFX.
- EMIT_PFX: hold inst stable while out_ready=0. On out_ready, load the main word (out_valid stays 1) and go to EMIT_MAIN. in_ready=0.
- EMIT_MAIN: hold the word. On out_ready, go to IDLE. out_valid drops unless a new accept happens the same cycle; in_ready=0 in this state, so out_valid drops.
- Output stability: inst and inst_is_pfx must not change while out_valid && !out_ready.
- word_cnt increments on every out_valid && out_ready, including PREFIX words, and saturates at 2^CNT_W-1.
- in_valid while in_ready=0 is ignored; the producer must hold its fields.

Decomposition:
- Shared package ins_pkg:
  - opcode width and PFX_OP constant
  - inst field positions (OP_MSB/LSB, RD_MSB/LSB, IMM5_MSB/LSB)
  - state enum {IDLE, EMIT_PFX, EMIT_MAIN}
  - function fits_imm5(imm)
- Sub-module: ins_out_reg, the output holding register with valid/ready stall logic and the saturating word counter. The FSM lives in ins_encode.

Test Plan:
- op=4'h3, rd=3'd2, imm=13'h0005, out_ready=1 -> 1 cycle later inst=12'h345, inst_is_pfx=0, word_cnt=1; in_ready stays 1.
- op=4'h3, rd=3'd1, imm=13'h1FF0 (=-16) -> single word inst=12'h330, inst_is_pfx=0.
- op=4'h3, rd=3'd1, imm=13'h0123 -> PREFIX inst=12'hF09, inst_is_pfx=1; then main word inst=12'h323; word_cnt=2.
- Same long-form input with out_ready=0 for 3 cycles -> inst holds 12'hF09 and in_ready=0 throughout; release -> main word follows, no words lost.
- op=4'hF -> err_illegal pulses for exactly 1 cycle, out_valid stays 0, word_cnt unchanged.
- rst_n driven low while in EMIT_PFX -> out_valid=0 immediately (async); after release, state IDLE, word_cnt=0, no main word emitted.

Source files
------------

// File: rtl/ins_encode_pkg.sv
// ins_pkg: shared constants and types for the instruction encoder.
//   - opcode width and the opcode reserved for PREFIX words
//   - bit positions of the fields in the 12-bit instruction word
//   - encoder FSM state type
//   - fits_imm5(): true when an immediate sign-extends from 5 bits
package ins_pkg;

  localparam int          OP_W      = 4;
  localparam int          RD_W      = 3;
  localparam int          INST_W    = 12;
  localparam int          IMM_MAX_W = 13;
  localparam logic [3:0]  PFX_OP    = 4'hF;

  localparam int OP_MSB   = 11;
  localparam int OP_LSB   = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 5;
  localparam int IMM5_MSB = 4;
  localparam int IMM5_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT_PFX  = 2'd1,
    EMIT_MAIN = 2'd2
  } state_t;

  // The caller sign-extends its immediate to IMM_MAX_W bits first; sign
  // extension does not change whether bits [MSB:4] are all equal.
  function automatic logic fits_imm5(input logic [IMM_MAX_W-1:0] imm);
    return (imm[IMM_MAX_W-1:4] == '0) || (imm[IMM_MAX_W-1:4] == '1);
  endfunction

endpackage

// File: rtl/ins_encode_if.sv
// ins_encode_if: groups the field-input handshake, the instruction-word
// output handshake and the status outputs of the encoder.
//   master : the encoder itself (accepts fields, drives words/status)
//   slave  : the surroundings (sequencer drives fields, bus drives out_ready)
// Signals: in_valid/in_ready/in_op/in_rd/in_imm, out_valid/out_ready/inst/
//          inst_is_pfx, err_illegal, word_cnt.
interface ins_encode_if #(
  parameter int IMM_W = 13,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [2:0]       in_rd;
  logic [IMM_W-1:0] in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      inst;
  logic             inst_is_pfx;
  logic             err_illegal;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    input  in_valid, in_op, in_rd, in_imm, out_ready,
    output in_ready, out_valid, inst, inst_is_pfx, err_illegal, word_cnt
  );

  modport slave (
    output in_valid, in_op, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, inst, inst_is_pfx, err_illegal, word_cnt
  );

endinterface

// File: rtl/ins_encode_out_reg.sv
// ins_out_reg: output holding register for the instruction bus.
//   load/load_inst/load_pfx : new word to present (takes priority over a
//                             transfer in the same cycle, giving back-to-back)
//   out_ready               : downstream accepts the presented word
//   out_valid/inst/inst_is_pfx : presented word, held while stalled
//   word_cnt                : saturating count of transferred words
module ins_out_reg
  import ins_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [11:0]      load_inst,
  input  logic             load_pfx,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [11:0]      inst,
  output logic             inst_is_pfx,
  output logic [CNT_W-1:0] word_cnt
);

  logic             valid_reg;
  logic [11:0]      inst_reg;
  logic             pfx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fire;

  assign fire = valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      inst_reg  <= 12'h000;
      pfx_reg   <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      inst_reg  <= load_inst;
      pfx_reg   <= load_pfx;
    end else if (fire) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (fire && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid   = valid_reg;
  assign inst        = inst_reg;
  assign inst_is_pfx = pfx_reg;
  assign word_cnt    = cnt_reg;

endmodule

// File: rtl/ins_encode.sv
// ins_encode: turns decoded operation fields into 12-bit instruction words.
// Immediates that do not sign-extend from 5 bits are issued as a PREFIX word
// (PFX_OP, imm[IMM_W-1:5]) followed by the main word (op, rd, imm[4:0]).
// Ports: clk, rst_n (async active-low), bus (ins_encode_if.master) carrying
//        the field handshake, the word handshake, err_illegal and word_cnt.
module ins_encode
  import ins_pkg::*;
#(
  parameter int         IMM_W  = 13,
  parameter logic [3:0] PFX_OP = ins_pkg::PFX_OP,
  parameter int         CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  ins_encode_if.master bus
);

  state_t      state_reg, state_next;
  logic [3:0]  op_reg, op_next;
  logic [2:0]  rd_reg, rd_next;
  logic [4:0]  imm5_reg, imm5_next;
  logic        err_reg, err_next;

  logic        load;
  logic [11:0] load_inst;
  logic        load_pfx;
  logic        out_valid;
  logic        in_ready;
  logic        accept;

  logic [IMM_MAX_W-1:0] imm_sx;
  logic [7:0]           pfx_bits;

  // Sign-extend the immediate to the width fits_imm5() expects, and build the
  // zero-extended upper part that travels in the PREFIX word.
  generate
    for (genvar gi = 0; gi < IMM_MAX_W; gi++) begin : g_sx
      if (gi < IMM_W) begin : g_in
        assign imm_sx[gi] = bus.in_imm[gi];
      end else begin : g_ext
        assign imm_sx[gi] = bus.in_imm[IMM_W-1];
      end
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_pfx
      if (gi < IMM_W - 5) begin : g_in
        assign pfx_bits[gi] = bus.in_imm[gi+5];
      end else begin : g_zero
        assign pfx_bits[gi] = 1'b0;
      end
    end
  endgenerate

  // Ready only in IDLE when the output slot is empty or draining this cycle;
  // held low throughout reset.
  assign in_ready = rst_n && (state_reg == IDLE) && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= 4'h0;
      rd_reg    <= 3'd0;
      imm5_reg  <= 5'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      rd_reg    <= rd_next;
      imm5_reg  <= imm5_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    rd_next    = rd_reg;
    imm5_next  = imm5_reg;
    err_next   = 1'b0;
    load       = 1'b0;
    load_inst  = 12'h000;
    load_pfx   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.in_op == PFX_OP) begin
            err_next = 1'b1;
          end else if (fits_imm5(imm_sx)) begin
            load      = 1'b1;
            load_inst = {bus.in_op, bus.in_rd, bus.in_imm[4:0]};
          end else begin
            load       = 1'b1;
            load_inst  = {PFX_OP, pfx_bits};
            load_pfx   = 1'b1;
            op_next    = bus.in_op;
            rd_next    = bus.in_rd;
            imm5_next  = bus.in_imm[4:0];
            state_next = EMIT_PFX;
          end
        end
      end
      EMIT_PFX: begin
        // out_valid is always set here, so out_ready alone means transfer.
        if (bus.out_ready) begin
          load       = 1'b1;
          load_inst  = {op_reg, rd_reg, imm5_reg};
          state_next = EMIT_MAIN;
        end
      end
      EMIT_MAIN: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  ins_out_reg #(
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_inst  (load_inst),
    .load_pfx   (load_pfx),
    .out_ready  (bus.out_ready),
    .out_valid  (out_valid),
    .inst       (bus.inst),
    .inst_is_pfx(bus.inst_is_pfx),
    .word_cnt   (bus.word_cnt)
  );

  assign bus.out_valid   = out_valid;
  assign bus.in_ready    = in_ready;
  assign bus.err_illegal = err_reg;

endmodule

// File: tb/tb_ins_encode.sv
// tb_ins_encode: directed stimulus with hand-computed expected words pushed
// into a scoreboard; a monitor pops and compares on every transfer.
module tb_ins_encode;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [12:0] sb[$];   // {is_pfx, inst}

  ins_encode_if #(.IMM_W(13), .CNT_W(16)) bus ();

  ins_encode #(.IMM_W(13), .PFX_OP(4'hF), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one set of fields and pushes the expected words on acceptance.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [12:0] imm,
                      input int n_exp, input logic [12:0] e0, input logic [12:0] e1);
    bit acc;
    @(posedge clk);
    #1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 (op=%h imm=%h)", op, imm);
    end else begin
      if (n_exp > 0) sb.push_back(e0);
      if (n_exp > 1) sb.push_back(e1);
      $display("issue op=%h rd=%0d imm=%h", op, rd, imm);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: scoreboard compare on every transfer, plus stall stability.
  initial begin
    logic        stalled;
    logic [11:0] prev_inst;
    logic        prev_pfx;
    logic [12:0] exp;
    stalled = 1'b0;
    prev_inst = '0;
    prev_pfx = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_hold", {19'd0, bus.inst_is_pfx, bus.inst}, {19'd0, prev_pfx, prev_inst});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got inst=%h pfx=%b expected none", bus.inst, bus.inst_is_pfx);
          end else begin
            exp = sb.pop_front();
            $display("xfer inst=%h pfx=%b", bus.inst, bus.inst_is_pfx);
            chk("word", {19'd0, bus.inst_is_pfx, bus.inst}, {19'd0, exp});
          end
        end
        stalled   = bus.out_valid && !bus.out_ready;
        prev_inst = bus.inst;
        prev_pfx  = bus.inst_is_pfx;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'h0;
    bus.in_rd     = 3'd0;
    bus.in_imm    = 13'h0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_inst", {20'd0, bus.inst}, 32'h000);
    chk("rst_pfx", {31'd0, bus.inst_is_pfx}, 32'd0);
    chk("rst_err", {31'd0, bus.err_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cnt", {16'd0, bus.word_cnt}, 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Short form, positive.
    send(4'h3, 3'd2, 13'h0005, 1, {1'b0, 12'h345}, 13'h0);
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    wait_cycles(2);
    chk("t1_cnt", {16'd0, bus.word_cnt}, 32'd1);

    // Short form, -16 is the most negative 5-bit value.
    send(4'h3, 3'd1, 13'h1FF0, 1, {1'b0, 12'h330}, 13'h0);
    wait_cycles(2);
    chk("t2_cnt", {16'd0, bus.word_cnt}, 32'd2);

    // Long form.
    send(4'h3, 3'd1, 13'h0123, 2, {1'b1, 12'hF09}, {1'b0, 12'h323});
    wait_cycles(3);
    chk("t3_cnt", {16'd0, bus.word_cnt}, 32'd4);

    // Boundary: +15 fits, +16 needs a prefix, -256 needs a prefix.
    send(4'h1, 3'd0, 13'h000F, 1, {1'b0, 12'h10F}, 13'h0);
    send(4'h1, 3'd0, 13'h0010, 2, {1'b1, 12'hF00}, {1'b0, 12'h110});
    send(4'h5, 3'd7, 13'h1F00, 2, {1'b1, 12'hFF8}, {1'b0, 12'h5E0});
    wait_cycles(3);
    chk("t4_cnt", {16'd0, bus.word_cnt}, 32'd9);

    // Long form with the bus stalled for 3 cycles on the prefix.
    bus.out_ready = 1'b0;
    send(4'h3, 3'd1, 13'h0123, 2, {1'b1, 12'hF09}, {1'b0, 12'h323});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_inst", {20'd0, bus.inst}, 32'hF09);
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_cycles(4);
    chk("stall_cnt", {16'd0, bus.word_cnt}, 32'd11);

    // Illegal opcode is dropped with a one-cycle error pulse.
    send(4'hF, 3'd3, 13'h0001, 0, 13'h0, 13'h0);
    chk("ill_err_hi", {31'd0, bus.err_illegal}, 32'd1);
    chk("ill_no_valid", {31'd0, bus.out_valid}, 32'd0);
    wait_cycles(1);
    chk("ill_err_lo", {31'd0, bus.err_illegal}, 32'd0);
    chk("ill_cnt", {16'd0, bus.word_cnt}, 32'd11);

    // Reset while the prefix is pending.
    bus.out_ready = 1'b0;
    send(4'h3, 3'd1, 13'h0123, 2, {1'b1, 12'hF09}, {1'b0, 12'h323});
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_cnt", {16'd0, bus.word_cnt}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    sb.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    wait_cycles(4);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_cnt", {16'd0, bus.word_cnt}, 32'd0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
